// File: rtl/uart_bus_ctrl.sv
// Memory-mapped 8N1 UART for the TXD/RXD/CON window of the CPU data bus.
// Read_data is zero outside the window so the bus top can OR it with DataMemory.
module uart_bus_ctrl #(
    parameter int unsigned BAUD_DIV  = 10417,
    parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        Mem_rd,
    input  logic        Mem_wr,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam logic [15:0] LP_BIT_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] LP_HALF_LAST = 16'((BAUD_DIV / 2) - 1);
    localparam logic [31:0] LP_TXD_ADDR  = BASE_ADDR;
    localparam logic [31:0] LP_RXD_ADDR  = BASE_ADDR + 32'd4;
    localparam logic [31:0] LP_CON_ADDR  = BASE_ADDR + 32'd8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]  r_tx_state;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic        r_tx;

    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_prev;
    logic [1:0]  r_rx_state;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_rx_data;

    logic        r_tx_irq_en;
    logic        r_rx_irq_en;
    logic        r_tx_done;
    logic        r_rx_ready;
    logic        r_rx_overrun;
    logic        r_irq;

    logic        w_sel_txd;
    logic        w_sel_rxd;
    logic        w_sel_con;
    logic        w_wr_txd;
    logic        w_wr_con;
    logic        w_rd_rxd;
    logic        w_tx_busy;
    logic        w_tx_end;
    logic        w_rx_stop_end;
    logic        w_rx_load;
    logic [31:0] w_con_value;
    logic        w_unused;

    assign w_sel_txd = (addr == LP_TXD_ADDR);
    assign w_sel_rxd = (addr == LP_RXD_ADDR);
    assign w_sel_con = (addr == LP_CON_ADDR);
    assign w_wr_txd  = Mem_wr & w_sel_txd;
    assign w_wr_con  = Mem_wr & w_sel_con;
    assign w_rd_rxd  = Mem_rd & w_sel_rxd;

    assign w_tx_busy     = (r_tx_state != ST_IDLE);
    assign w_tx_end      = (r_tx_state == ST_STOP) && (r_tx_cnt == LP_BIT_LAST);
    assign w_rx_stop_end = (r_rx_state == ST_STOP) && (r_rx_cnt == LP_BIT_LAST);
    assign w_rx_load     = w_rx_stop_end & r_rx_s2;

    assign w_con_value = {26'b0, r_rx_overrun, w_tx_busy, r_rx_ready,
                          r_tx_done, r_rx_irq_en, r_tx_irq_en};
    assign w_unused    = ^Write_data[31:8];

    assign uart_tx = r_tx;
    assign irq     = r_irq;

    always_comb begin
        Read_data = '0;
        if (Mem_rd) begin
            if (w_sel_rxd) begin
                Read_data = {24'b0, r_rx_data};
            end else if (w_sel_con) begin
                Read_data = w_con_value;
            end
        end
    end

    // Transmitter: each state is held for exactly BAUD_DIV cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                ST_IDLE: begin
                    if (w_wr_txd) begin
                        r_tx_shift <= Write_data[7:0];
                        r_tx_cnt   <= '0;
                        r_tx       <= 1'b0;
                        r_tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_tx_cnt == LP_BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_state <= ST_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (r_tx_cnt == LP_BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= ST_STOP;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (r_tx_cnt == LP_BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= ST_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                default: r_tx_state <= ST_IDLE;
            endcase
        end
    end

    // Receiver: start bit is re-checked half a bit after the synced falling edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1   <= uart_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            case (r_rx_state)
                ST_IDLE: begin
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_rx_cnt == LP_HALF_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_state <= r_rx_s2 ? ST_IDLE : ST_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (r_rx_cnt == LP_BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= ST_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (r_rx_cnt == LP_BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= ST_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                default: r_rx_state <= ST_IDLE;
            endcase
        end
    end

    // Flag set events take priority over the W1C clear and the RXD read clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx_irq_en  <= 1'b0;
            r_rx_irq_en  <= 1'b0;
            r_tx_done    <= 1'b0;
            r_rx_ready   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_rx_data    <= '0;
            r_irq        <= 1'b0;
        end else begin
            if (w_wr_con) begin
                r_tx_irq_en <= Write_data[0];
                r_rx_irq_en <= Write_data[1];
            end

            if (w_tx_end) begin
                r_tx_done <= 1'b1;
            end else if (w_wr_con && Write_data[2]) begin
                r_tx_done <= 1'b0;
            end

            if (w_rx_load) begin
                r_rx_data  <= r_rx_shift;
                r_rx_ready <= 1'b1;
            end else if (w_rd_rxd) begin
                r_rx_ready <= 1'b0;
            end

            if (w_rx_load && r_rx_ready && !w_rd_rxd) begin
                r_rx_overrun <= 1'b1;
            end else if (w_wr_con && Write_data[5]) begin
                r_rx_overrun <= 1'b0;
            end

            r_irq <= (r_tx_done & r_tx_irq_en) | (r_rx_ready & r_rx_irq_en);
        end
    end

endmodule
